// File: rtl/soml_pkg.sv
// soml_pkg: shared types and defaults for the SOML decoder control slice.
//   state_t    : frame sequencer states
//   DEF_*      : default geometry / latency of the decoder datapath
//   cand_w()   : index width for a count, never narrower than 1 bit
package soml_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    SWEEP = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam int DEF_N_ROW    = 2;
  localparam int DEF_N_COL    = 2;
  localparam int DEF_N_CAND   = 16;
  localparam int DEF_PIPE_LAT = 4;
  localparam int ADDR_W       = 2;

  function automatic int cand_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/soml_vld_delay.sv
// soml_vld_delay: PIPE_LAT-stage 1-bit shift register that carries the
// "candidate metric complete" marker down the datapath latency.
//   clk, rst : clock, asynchronous active-high reset
//   clr_i    : synchronous clear of every stage (frame abort)
//   d_i      : marker in
//   q_o      : marker after PIPE_LAT cycles
module soml_vld_delay #(
  parameter int PIPE_LAT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic d_i,
  output logic q_o
);

  logic [PIPE_LAT-1:0] sr_q;
  logic [PIPE_LAT-1:0] sr_d;

  always_comb begin
    sr_d    = '0;
    sr_d[0] = d_i;
    for (int i = 1; i < PIPE_LAT; i++) begin
      sr_d[i] = sr_q[i-1];
    end
    if (clr_i) sr_d = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sr_q <= '0;
    else     sr_q <= sr_d;
  end

  assign q_o = sr_q[PIPE_LAT-1];

endmodule

// File: rtl/soml_decode_ctrl.sv
// soml_decode_ctrl: frame-level sequencer for the SOML decoder datapath.
// After an accepted start it pulses the address-generator restart, sweeps
// every (row H, col S) element for each candidate, waits out the datapath
// latency and pulses done.
//   start_i / start_rdy_o      : frame handshake (ready only in IDLE)
//   abort_i                    : synchronous abort back to IDLE, no done
//   agen_ena_o                 : address generator restart pulse
//   rd_en_o, mac_en_o          : buffer read / accumulate strobes
//   addr_colS_o, addr_rowH_o   : element address, col fastest
//   cand_idx_o                 : current candidate
//   mac_clr_o                  : accumulator clear on a candidate's first element
//   cmp_en_o                   : candidate metric ready at the min-compare stage
//   busy_o, done_o             : frame in progress / frame decision valid
module soml_decode_ctrl
  import soml_pkg::*;
#(
  parameter  int N_ROW    = DEF_N_ROW,
  parameter  int N_COL    = DEF_N_COL,
  parameter  int N_CAND   = DEF_N_CAND,
  parameter  int PIPE_LAT = DEF_PIPE_LAT,
  localparam int CAND_W   = cand_w(N_CAND)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic              abort_i,
  output logic              start_rdy_o,
  output logic              agen_ena_o,
  output logic              rd_en_o,
  output logic [ADDR_W-1:0] addr_colS_o,
  output logic [ADDR_W-1:0] addr_rowH_o,
  output logic [CAND_W-1:0] cand_idx_o,
  output logic              mac_clr_o,
  output logic              mac_en_o,
  output logic              cmp_en_o,
  output logic              busy_o,
  output logic              done_o
);

  localparam int DR_W = cand_w(PIPE_LAT);
  localparam logic [ADDR_W-1:0] COL_LAST  = ADDR_W'(N_COL - 1);
  localparam logic [ADDR_W-1:0] ROW_LAST  = ADDR_W'(N_ROW - 1);
  localparam logic [CAND_W-1:0] CAND_LAST = CAND_W'(N_CAND - 1);
  localparam logic [DR_W-1:0]   DR_LAST   = DR_W'(PIPE_LAT - 1);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   col_q, col_d;
  logic [ADDR_W-1:0]   row_q, row_d;
  logic [CAND_W-1:0]   cand_q, cand_d;
  logic [DR_W-1:0]     drain_q, drain_d;
  logic                start_rdy_q, start_rdy_d;
  logic                agen_ena_q, agen_ena_d;
  logic                rd_en_q, rd_en_d;
  logic                mac_clr_q, mac_clr_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                last_elem;

  // Marks the final element of the candidate being read this cycle.
  assign last_elem = (state_q == SWEEP) && (row_q == ROW_LAST) && (col_q == COL_LAST);

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    cand_d  = cand_q;
    drain_d = drain_q;

    case (state_q)
      IDLE: begin
        if (start_i && !abort_i) state_d = LOAD;
      end
      LOAD: begin
        col_d   = '0;
        row_d   = '0;
        cand_d  = '0;
        state_d = SWEEP;
      end
      SWEEP: begin
        if (col_q == COL_LAST) begin
          col_d = '0;
          if (row_q == ROW_LAST) begin
            row_d = '0;
            if (cand_q == CAND_LAST) begin
              cand_d  = '0;
              drain_d = '0;
              state_d = DRAIN;
            end else begin
              cand_d = cand_q + CAND_W'(1);
            end
          end else begin
            row_d = row_q + ADDR_W'(1);
          end
        end else begin
          col_d = col_q + ADDR_W'(1);
        end
      end
      DRAIN: begin
        if (drain_q == DR_LAST) begin
          drain_d = '0;
          state_d = DONE;
        end else begin
          drain_d = drain_q + DR_W'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Abort overrides every transition; in IDLE this is already the idle state.
    if (abort_i) begin
      state_d = IDLE;
      col_d   = '0;
      row_d   = '0;
      cand_d  = '0;
      drain_d = '0;
    end

    // Outputs are decoded from the next state so they register in step with it.
    start_rdy_d = (state_d == IDLE);
    agen_ena_d  = (state_d == LOAD);
    rd_en_d     = (state_d == SWEEP);
    mac_clr_d   = (state_d == SWEEP) && (row_d == '0) && (col_d == '0);
    busy_d      = (state_d != IDLE);
    done_d      = (state_d == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      col_q       <= '0;
      row_q       <= '0;
      cand_q      <= '0;
      drain_q     <= '0;
      start_rdy_q <= 1'b1;
      agen_ena_q  <= 1'b0;
      rd_en_q     <= 1'b0;
      mac_clr_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      row_q       <= row_d;
      cand_q      <= cand_d;
      drain_q     <= drain_d;
      start_rdy_q <= start_rdy_d;
      agen_ena_q  <= agen_ena_d;
      rd_en_q     <= rd_en_d;
      mac_clr_q   <= mac_clr_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  soml_vld_delay #(
    .PIPE_LAT (PIPE_LAT)
  ) u_vld_delay (
    .clk   (clk),
    .rst   (rst),
    .clr_i (abort_i),
    .d_i   (last_elem),
    .q_o   (cmp_en_o)
  );

  assign start_rdy_o = start_rdy_q;
  assign agen_ena_o  = agen_ena_q;
  assign rd_en_o     = rd_en_q;
  assign mac_en_o    = rd_en_q;
  assign mac_clr_o   = mac_clr_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign addr_colS_o = col_q;
  assign addr_rowH_o = row_q;
  assign cand_idx_o  = cand_q;

endmodule

// File: tb/tb_soml_decode_ctrl.sv
module tb_soml_decode_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start_i = 1'b0;
  logic abort_i = 1'b0;
  logic start_b = 1'b0;
  logic abort_b = 1'b0;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // DUT A: default geometry
  logic       start_rdy_o, agen_ena_o, rd_en_o, mac_clr_o, mac_en_o, cmp_en_o, busy_o, done_o;
  logic [1:0] addr_colS_o, addr_rowH_o;
  logic [3:0] cand_idx_o;

  soml_decode_ctrl u_dut (
    .clk(clk), .rst(rst), .start_i(start_i), .abort_i(abort_i),
    .start_rdy_o(start_rdy_o), .agen_ena_o(agen_ena_o), .rd_en_o(rd_en_o),
    .addr_colS_o(addr_colS_o), .addr_rowH_o(addr_rowH_o), .cand_idx_o(cand_idx_o),
    .mac_clr_o(mac_clr_o), .mac_en_o(mac_en_o), .cmp_en_o(cmp_en_o),
    .busy_o(busy_o), .done_o(done_o)
  );

  // DUT B: PIPE_LAT=1, N_CAND=4
  logic       b_rdy, b_agen, b_rd, b_clr, b_en, b_cmp, b_busy, b_done;
  logic [1:0] b_col, b_row, b_cand;

  soml_decode_ctrl #(.N_CAND(4), .PIPE_LAT(1)) u_dut_b (
    .clk(clk), .rst(rst), .start_i(start_b), .abort_i(abort_b),
    .start_rdy_o(b_rdy), .agen_ena_o(b_agen), .rd_en_o(b_rd),
    .addr_colS_o(b_col), .addr_rowH_o(b_row), .cand_idx_o(b_cand),
    .mac_clr_o(b_clr), .mac_en_o(b_en), .cmp_en_o(b_cmp),
    .busy_o(b_busy), .done_o(b_done)
  );

  typedef struct packed {
    logic [31:0] c;
    logic [3:0]  cand;
    logic [1:0]  row;
    logic [1:0]  col;
  } rd_t;

  rd_t q_rd[$];
  int  q_agen[$], q_mac[$], q_cmp[$], q_done[$];
  int  qb_cmp[$], qb_done[$];

  int n_cmp = 0;
  int n_bad = 0;
  int t0;

  task automatic cmp_val(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Expected events of a default frame started at cycle s, truncated after cycle cut.
  task automatic push_frame(input int s, input int cut);
    rd_t e;
    if (s + 1 <= cut) q_agen.push_back(s + 1);
    for (int i = 0; i < 64; i++) begin
      e.c    = 32'(s + 2 + i);
      e.cand = 4'(i / 4);
      e.row  = 2'((i / 2) % 2);
      e.col  = 2'(i % 2);
      if (s + 2 + i <= cut) q_rd.push_back(e);
    end
    for (int k = 0; k < 16; k++) begin
      if (s + 2 + 4 * k <= cut) q_mac.push_back(s + 2 + 4 * k);
      if (s + 9 + 4 * k <= cut) q_cmp.push_back(s + 9 + 4 * k);
    end
    if (s + 70 <= cut) q_done.push_back(s + 70);
  endtask

  task automatic check_idle(input string nm);
    cmp_val(nm, {16'h0, start_rdy_o, agen_ena_o, rd_en_o, mac_clr_o, mac_en_o, cmp_en_o,
                 busy_o, done_o, addr_colS_o, addr_rowH_o, cand_idx_o}, 32'h0000_8000);
  endtask

  task automatic chk_drained(input string nm);
    cmp_val(nm, 32'(q_rd.size() + q_agen.size() + q_mac.size() + q_cmp.size() +
                    q_done.size() + qb_cmp.size() + qb_done.size()), 32'd0);
  endtask

  // Monitor: pops the scoreboard whenever a DUT presents an event.
  always @(negedge clk) begin
    if (agen_ena_o) begin
      if (q_agen.size() == 0) cmp_val("agen_unexpected", cyc, 32'hFFFF_FFFF);
      else cmp_val("agen_cycle", cyc, q_agen.pop_front());
    end
    if (mac_clr_o) begin
      if (q_mac.size() == 0) cmp_val("mac_clr_unexpected", cyc, 32'hFFFF_FFFF);
      else cmp_val("mac_clr_cycle", cyc, q_mac.pop_front());
    end
    if (cmp_en_o) begin
      if (q_cmp.size() == 0) cmp_val("cmp_en_unexpected", cyc, 32'hFFFF_FFFF);
      else cmp_val("cmp_en_cycle", cyc, q_cmp.pop_front());
    end
    if (done_o) begin
      if (q_done.size() == 0) cmp_val("done_unexpected", cyc, 32'hFFFF_FFFF);
      else cmp_val("done_cycle", cyc, q_done.pop_front());
    end
    if (rd_en_o || mac_en_o) begin
      cmp_val("mac_en_eq_rd_en", {31'd0, mac_en_o}, {31'd0, rd_en_o});
      if (q_rd.size() == 0) cmp_val("rd_en_unexpected", cyc, 32'hFFFF_FFFF);
      else begin
        rd_t e;
        e = q_rd.pop_front();
        cmp_val("rd_cycle", cyc, e.c);
        cmp_val("rd_addr_cand_row_col", {24'd0, cand_idx_o, addr_rowH_o, addr_colS_o},
                {24'd0, e.cand, e.row, e.col});
      end
    end
    if (b_cmp) begin
      if (qb_cmp.size() == 0) cmp_val("b_cmp_en_unexpected", cyc, 32'hFFFF_FFFF);
      else cmp_val("b_cmp_en_cycle", cyc, qb_cmp.pop_front());
    end
    if (b_done) begin
      if (qb_done.size() == 0) cmp_val("b_done_unexpected", cyc, 32'hFFFF_FFFF);
      else cmp_val("b_done_cycle", cyc, qb_done.pop_front());
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values
    repeat (2) @(posedge clk);
    #1;
    check_idle("reset_outputs");
    cmp_val("reset_b_outputs", {27'd0, b_rdy, b_busy, b_done, b_cmp, b_rd}, 32'b10000);
    @(posedge clk);
    #1 rst = 1'b0;

    // Full frame on both DUTs
    @(posedge clk);
    #1;
    start_i = 1'b1;
    start_b = 1'b1;
    t0 = cyc;
    push_frame(t0, t0 + 1000);
    for (int k = 0; k < 4; k++) qb_cmp.push_back(t0 + 6 + 4 * k);
    qb_done.push_back(t0 + 19);
    @(posedge clk);
    #1;
    start_i = 1'b0;
    start_b = 1'b0;
    @(negedge clk);
    cmp_val("busy_in_load", {31'd0, busy_o}, 32'd1);
    cmp_val("start_rdy_in_load", {31'd0, start_rdy_o}, 32'd0);
    repeat (75) @(posedge clk);
    #1;
    chk_drained("frame1_leftover_events");
    check_idle("frame1_end_idle");

    // start_i held high: exactly one frame, next accepted at cycle 71
    @(posedge clk);
    #1;
    start_i = 1'b1;
    t0 = cyc;
    push_frame(t0, t0 + 1000);
    push_frame(t0 + 71, t0 + 1000);
    repeat (71) @(posedge clk);
    @(negedge clk);
    cmp_val("held_start_rdy_at_71", {31'd0, start_rdy_o}, 32'd1);
    @(posedge clk);
    #1 start_i = 1'b0;
    repeat (80) @(posedge clk);
    #1;
    chk_drained("held_start_leftover_events");
    check_idle("held_start_end_idle");

    // Abort at cycle 20
    @(posedge clk);
    #1;
    start_i = 1'b1;
    t0 = cyc;
    push_frame(t0, t0 + 20);
    @(posedge clk);
    #1 start_i = 1'b0;
    repeat (19) @(posedge clk);
    #1 abort_i = 1'b1;
    @(posedge clk);
    #1 abort_i = 1'b0;
    @(negedge clk);
    check_idle("abort_idle_at_21");
    repeat (80) @(posedge clk);
    #1;
    chk_drained("abort_leftover_events");

    // Asynchronous reset mid-DRAIN
    @(posedge clk);
    #1;
    start_i = 1'b1;
    t0 = cyc;
    push_frame(t0, t0 + 66);
    @(posedge clk);
    #1 start_i = 1'b0;
    repeat (66) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check_idle("async_rst_outputs");
    @(posedge clk);
    #2 rst = 1'b0;
    chk_drained("async_rst_leftover_events");
    @(posedge clk);
    #1;
    start_i = 1'b1;
    t0 = cyc;
    push_frame(t0, t0 + 1000);
    @(posedge clk);
    #1 start_i = 1'b0;
    repeat (75) @(posedge clk);
    #1;
    chk_drained("post_rst_frame_leftover_events");
    check_idle("post_rst_frame_idle");

    // start_i and abort_i together in IDLE
    @(posedge clk);
    #1;
    start_i = 1'b1;
    abort_i = 1'b1;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    abort_i = 1'b0;
    @(negedge clk);
    check_idle("start_with_abort_stays_idle");
    repeat (5) @(posedge clk);
    #1;
    chk_drained("start_with_abort_leftover_events");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
